alu_share_arbiter: RTL and testbench

- Shares the single LC-3 ALU (ADD/AND/NOT/PASS-A, 2-bit aluk) between NUM_REQ requesters, e.g. the datapath executor and an address/debug engine.
- Arbitrates round-robin, registers the operands, drives the external ALU, captures its combinational result and returns it over a valid/ready response channel tagged with the requester id.
- Sits between the requesters and the ALU instance.

---
 rtl/alu_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU share arbiter.
// Optional condition-code output is enabled by defining ALU_ARB_NZP_EN.
package alu_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward with wrap,
// returns a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned pos;
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IW'(pos);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one LC-3 ALU between NUM_REQ requesters with round-robin arbitration
// and a tagged valid/ready response. Define ALU_ARB_NZP_EN to add resp_nzp.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*2-1:0]     req_aluk,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [1:0]               alu_aluk,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_s,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     busy
`ifdef ALU_ARB_NZP_EN
    ,
    output logic [2:0]               resp_nzp
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     cur_id;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic [1:0]          sel_aluk;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (state == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grant is only ever asserted toward a valid requester, so any grant is an accept.
    assign req_ready = gnt;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_aluk = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                sel_aluk = req_aluk[2*i +: 2];
                sel_a    = req_a[WIDTH*i +: WIDTH];
                sel_b    = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_valid && resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers hold their last value outside EXEC so the ALU inputs stay quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= ID_W'(NUM_REQ - 1);
            cur_id     <= '0;
            alu_aluk   <= ALU_PASS;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (accept) begin
                alu_aluk <= sel_aluk;
                alu_a    <= sel_a;
                alu_b    <= sel_b;
                cur_id   <= gnt_idx;
                ptr      <= gnt_idx;
            end
            if (state == EXEC) begin
                resp_data  <= alu_s;
                resp_id    <= cur_id;
                resp_valid <= 1'b1;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_NZP_EN
    // Condition codes captured alongside resp_data; exactly one bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_nzp <= NZP_RESET;
        end else if (state == EXEC) begin
            resp_nzp <= {alu_s[WIDTH-1], (alu_s == '0), (!alu_s[WIDTH-1] && (alu_s != '0))};
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed ops, round-robin,
// backpressure, mid-operation reset and idle hold.
module tb_alu_share_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned ID_W    = 1;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*2-1:0]     req_aluk;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [1:0]               alu_aluk;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [WIDTH-1:0]         alu_s;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic                     busy;
`ifdef ALU_ARB_NZP_EN
    logic [2:0]               resp_nzp;
`endif

    alu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_aluk   (req_aluk),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .alu_aluk   (alu_aluk),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
`ifdef ALU_ARB_NZP_EN
        ,
        .resp_nzp   (resp_nzp)
`endif
    );

    // The external LC-3 ALU.
    always_comb begin
        case (alu_aluk)
            2'b00:   alu_s = alu_a + alu_b;
            2'b01:   alu_s = alu_a & alu_b;
            2'b10:   alu_s = ~alu_a;
            default: alu_s = alu_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
        logic [2:0]       nzp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   nresp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: handshake happens at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_resp: got id=%0d data=%0h expected no response", resp_id, resp_data);
            end else begin
                e = sb.pop_front();
                nresp++;
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_data", 32'(resp_data), 32'(e.data));
`ifdef ALU_ARB_NZP_EN
                check("resp_nzp", 32'(resp_nzp), 32'(e.nzp));
`endif
            end
        end
    end

    task automatic set_req(input int id, input logic [1:0] k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_aluk[id*2 +: 2]     = k;
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    function automatic exp_t mk(input int id, input logic [WIDTH-1:0] d, input logic [2:0] n);
        exp_t e;
        e.id   = ID_W'(id);
        e.data = d;
        e.nzp  = n;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int id, input logic [1:0] k, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] ed, input logic [2:0] en);
        set_req(id, k, a, b);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                sb.push_back(mk(id, ed, en));
                @(posedge clk);
                #1;
                req_valid[id] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
        fail_now("grant_timeout");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy && !resp_valid && sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail_now("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) return;
        end
        fail_now("resp_valid_timeout");
    endtask

    initial begin
        int exp_order[4] = '{0, 1, 0, 1};
        bit got;

        reset      = 1'b1;
        req_valid  = '0;
        req_aluk   = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_id", 32'(resp_id), 32'h0);
        check("rst_resp_data", 32'(resp_data), 32'h0);
        check("rst_alu_aluk", 32'(alu_aluk), 32'h3);
        check("rst_alu_a", 32'(alu_a), 32'h0);
        check("rst_alu_b", 32'(alu_b), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
`ifdef ALU_ARB_NZP_EN
        check("rst_nzp", 32'(resp_nzp), 32'h2);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single ADD with latency: EXEC in the cycle after accept, response in the one after
        issue(0, 2'b00, 16'h0005, 16'h0003, 16'h0008, 3'b001);
        @(negedge clk);
        check("lat_exec_resp_valid", 32'(resp_valid), 32'h0);
        check("lat_exec_busy", 32'(busy), 32'h1);
        check("lat_exec_alu_a", 32'(alu_a), 32'h5);
        check("lat_exec_alu_b", 32'(alu_b), 32'h3);
        check("lat_exec_alu_aluk", 32'(alu_aluk), 32'h0);
        @(negedge clk);
        check("lat_resp_valid", 32'(resp_valid), 32'h1);
        @(posedge clk);
        #1;
        wait_idle();

        // Opcode coverage
        issue(0, 2'b01, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001);
        wait_idle();
        issue(0, 2'b10, 16'h0000, 16'h5555, 16'hFFFF, 3'b100);
        wait_idle();
        issue(0, 2'b11, 16'h1234, 16'h9999, 16'h1234, 3'b001);
        wait_idle();
        issue(0, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 3'b010);
        wait_idle();
        issue(1, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 3'b100);
        wait_idle();

        // Round robin with both requesters held valid
        set_req(0, 2'b00, 16'h0100, 16'h0001);
        set_req(1, 2'b01, 16'hFFFF, 16'h00FF);
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (|req_ready) begin
                    got = 1'b1;
                    check("rr_grant", 32'(req_ready), 32'(1) << exp_order[g]);
                    if (exp_order[g] == 0) sb.push_back(mk(0, 16'h0101, 3'b001));
                    else                   sb.push_back(mk(1, 16'h00FF, 3'b001));
                end
                @(posedge clk);
                #1;
            end
            if (!got) fail_now("rr_timeout");
        end
        req_valid = '0;
        wait_idle();

        // Backpressure holds RESP and stalls the other requester
        resp_ready = 1'b0;
        issue(0, 2'b00, 16'h1111, 16'h2222, 16'h3333, 3'b001);
        set_req(1, 2'b11, 16'hABCD, 16'h0000);
        req_valid[1] = 1'b1;
        wait_resp_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", 32'(resp_valid), 32'h1);
            check("bp_resp_data", 32'(resp_data), 32'h3333);
            check("bp_resp_id", 32'(resp_id), 32'h0);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_busy", 32'(busy), 32'h1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_busy", 32'(busy), 32'h0);
        check("bp_next_grant", 32'(req_ready), 32'h2);
        if (req_ready[1]) sb.push_back(mk(1, 16'hABCD, 3'b100));
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_idle();

        // Asynchronous reset while a response is pending
        resp_ready = 1'b0;
        issue(0, 2'b11, 16'h0042, 16'h0000, 16'h0042, 3'b001);
        wait_resp_valid();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_resp_valid", 32'(resp_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_resp_data", 32'(resp_data), 32'h0);
        check("arst_alu_a", 32'(alu_a), 32'h0);
        if (sb.size() != 0) void'(sb.pop_back());
        set_req(0, 2'b00, 16'h0002, 16'h0002);
        set_req(1, 2'b10, 16'h00FF, 16'h0000);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_grant", 32'(req_ready), 32'h1);
        if (req_ready[0]) sb.push_back(mk(0, 16'h0004, 3'b001));
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                got = 1'b1;
                sb.push_back(mk(1, 16'hFF00, 3'b100));
            end
            @(posedge clk);
            #1;
        end
        if (!got) fail_now("post_reset_req1_timeout");
        req_valid = '0;
        wait_idle();

        // Idle: outputs quiet, ALU inputs hold the last accepted operands
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_req_ready", 32'(req_ready), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_alu_aluk", 32'(alu_aluk), 32'h2);
            check("idle_alu_a", 32'(alu_a), 32'h00FF);
            check("idle_alu_b", 32'(alu_b), 32'h0000);
        end

        check("sb_empty", 32'(sb.size()), 32'h0);
        check("resp_count", 32'(nresp), 32'd14);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
